// File: rtl/mips_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch sequencer.
package mips_pkg;

  localparam logic [5:0]  OP_BEQ    = 6'b000100;
  localparam logic [5:0]  OP_J      = 6'b000010;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESOLVE = 3'd3,
    S_ADVANCE = 3'd4,
    S_PC_WAIT = 3'd5
  } if_state_e;

endpackage

// File: rtl/if_field_extract.sv
// Combinational split of an instruction word into opcode, sign-extended
// branch offset (word units, unshifted) and 26-bit jump target.
module if_field_extract #(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] i_instr,
  output logic [5:0]         o_opcode,
  output logic [INSTR_W-1:0] o_offset,
  output logic [25:0]        o_target
);

  assign o_opcode = i_instr[31:26];
  assign o_offset = {{(INSTR_W-16){i_instr[15]}}, i_instr[15:0]};
  assign o_target = i_instr[25:0];

endmodule

// File: rtl/instr_fetch_32.sv
// Instruction fetch sequencer between pc_control_32 and decode.
// Optional halt detection is enabled by defining IF_HALT_DETECT_EN.
module instr_fetch_32
  import mips_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] pc,
  input  logic               pc_finish,
  output logic               pc_start,
  output logic               beq,
  output logic               jump,
  output logic [INSTR_W-1:0] branch_offset,
  output logic [25:0]        jump_addr,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_valid,
  input  logic               br_taken,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  if_state_e          r_state;
  if_state_e          w_next;
  logic               r_pc_start;
  logic               r_imem_req;
  logic [INSTR_W-1:0] r_imem_addr;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic               r_beq;
  logic               r_jump;
  logic [INSTR_W-1:0] r_branch_offset;
  logic [25:0]        r_jump_addr;
  logic               r_halted;
  logic [CNT_W-1:0]   r_fetch_count;

  logic [5:0]         w_opcode;
  logic [INSTR_W-1:0] w_offset;
  logic [25:0]        w_target;
  logic               w_is_halt;
  logic               w_issue_hs;

  if_field_extract #(.INSTR_W(INSTR_W)) u_field_extract (
    .i_instr  (r_instr),
    .o_opcode (w_opcode),
    .o_offset (w_offset),
    .o_target (w_target)
  );

`ifdef IF_HALT_DETECT_EN
  assign w_is_halt = (r_instr == HALT_WORD);
`else
  assign w_is_halt = 1'b0;
`endif

  assign w_issue_hs = (r_state == S_ISSUE) && instr_ready;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (run && !r_halted) w_next = S_FETCH;
        else                  w_next = S_IDLE;
      end
      S_FETCH: begin
        if (imem_ack) w_next = S_ISSUE;
        else          w_next = S_FETCH;
      end
      S_ISSUE: begin
        if (!instr_ready)             w_next = S_ISSUE;
        else if (w_is_halt)           w_next = S_IDLE;
        else if (w_opcode == OP_BEQ)  w_next = S_RESOLVE;
        else                          w_next = S_ADVANCE;
      end
      S_RESOLVE: begin
        if (br_valid) w_next = S_ADVANCE;
        else          w_next = S_RESOLVE;
      end
      // finish may coincide with the start pulse, so ADVANCE samples it too
      S_ADVANCE, S_PC_WAIT: begin
        if (pc_finish) w_next = run ? S_FETCH : S_IDLE;
        else           w_next = S_PC_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_pc_start      <= 1'b0;
      r_imem_req      <= 1'b0;
      r_imem_addr     <= {INSTR_W{1'b0}};
      r_instr         <= {INSTR_W{1'b0}};
      r_instr_valid   <= 1'b0;
      r_beq           <= 1'b0;
      r_jump          <= 1'b0;
      r_branch_offset <= {INSTR_W{1'b0}};
      r_jump_addr     <= 26'd0;
      r_halted        <= 1'b0;
      r_fetch_count   <= {CNT_W{1'b0}};
    end else begin
      r_state       <= w_next;
      r_pc_start    <= (w_next == S_ADVANCE);
      r_imem_req    <= (w_next == S_FETCH);
      r_instr_valid <= (w_next == S_ISSUE);
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
        r_imem_addr <= pc;
      end
      if ((r_state == S_FETCH) && imem_ack) begin
        r_instr <= imem_rdata;
      end
      if (w_issue_hs) begin
        r_fetch_count   <= r_fetch_count + {{(CNT_W-1){1'b0}}, 1'b1};
        r_branch_offset <= w_offset;
        r_jump_addr     <= w_target;
        r_beq           <= 1'b0;
        r_jump          <= !w_is_halt && (w_opcode == OP_J);
        if (w_is_halt) r_halted <= 1'b1;
      end
      if ((r_state == S_RESOLVE) && br_valid) begin
        r_beq <= br_taken;
      end
    end
  end

  assign pc_start      = r_pc_start;
  assign imem_req      = r_imem_req;
  assign imem_addr     = r_imem_addr;
  assign instr         = r_instr;
  assign instr_valid   = r_instr_valid;
  assign beq           = r_beq;
  assign jump          = r_jump;
  assign branch_offset = r_branch_offset;
  assign jump_addr     = r_jump_addr;
  assign halted        = r_halted;
  assign fetch_count   = r_fetch_count;

endmodule

// File: doc/instr_fetch_32.md
# instr_fetch_32

Instruction fetch sequencer between `pc_control_32` and the decode stage. Reads the instruction at the current `pc` from instruction memory over a req/ack handshake and presents it to decode with valid/ready. Extracts the branch and jump fields and drives `pc_control_32`'s `beq`/`jump`/`branch_offset`/`jump_addr`/`start` inputs. Consumes `finish` before starting the next fetch.

## Interface
- `INSTR_W`, 32, instruction and data width
- `CNT_W`, 16, width of the retired-fetch counter
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  enable; fetching proceeds while high
- `pc`  in  32  current PC from `pc_control_32`
- `pc_finish`  in  1  `finish` pulse from `pc_control_32`
- `pc_start`  out  1  one-cycle `start` pulse to `pc_control_32`
- `beq`, `jump`  out  1 each  branch-taken and jump controls to `pc_control_32`
- `branch_offset`  out  32  sign-extended `instr[15:0]`, word offset, no shift applied here
- `jump_addr`  out  26  `instr[25:0]`
- `imem_req`  out  1  memory read request
- `imem_addr`  out  32  read address, equal to `pc` captured at request start
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  instruction word
- `instr`  out  32  fetched instruction
- `instr_valid`  out  1  `instr` offered to decode
- `instr_ready`  in  1  decode accepts
- `br_valid`  in  1  execute has resolved the pending beq
- `br_taken`  in  1  beq compare result, qualified by `br_valid`
- `halted`  out  1  halt encoding fetched (see Configuration)
- `fetch_count`  out  CNT_W  number of instructions accepted by decode

## Operation
- FSM states: IDLE, FETCH, ISSUE, RESOLVE, ADVANCE, PC_WAIT.
- **IDLE**: goes to FETCH when `run`=1 and `halted`=0.
- **FETCH**:
  - `imem_req`=1 and `imem_addr`=latched `pc`, both held until `imem_ack`.
  - On ack, latch `imem_rdata` into `instr` and go to ISSUE.
- **ISSUE**:
  - `instr_valid`=1 until `instr_ready`. `instr` is stable while valid.
  - On handshake, `fetch_count` increments (wraps at 2^CNT_W).
  - Opcode `instr[31:26]`=6'b000100 (beq) goes to RESOLVE.
  - Any other opcode goes to ADVANCE with `beq`=0. `jump`=1 iff opcode=6'b000010.
- **RESOLVE**: waits for `br_valid`; latches `beq`=`br_taken`; goes to ADVANCE. `jump`=0.
- **ADVANCE**: `pc_start`=1 for exactly one cycle, then PC_WAIT.
- **PC_WAIT**: on `pc_finish`, goes to FETCH if `run`=1, otherwise IDLE.
- `beq`, `jump`, `branch_offset` and `jump_addr` are registered. They stay stable from ADVANCE entry until the next ISSUE handshake.
- Dropping `run` mid-instruction does not abort. The current instruction completes through PC_WAIT, then the FSM idles.
- Reset mid-operation immediately returns all state to reset values. Any outstanding memory request is abandoned; memory must tolerate a dropped `imem_req`.

## Timing
- Reset values:
  - state=IDLE
  - `pc_start`=`imem_req`=`instr_valid`=`beq`=`jump`=`halted`=0
  - `instr`=0, `branch_offset`=0, `jump_addr`=0, `imem_addr`=0, `fetch_count`=0
- `imem_ack` may arrive in the first FETCH cycle (zero-wait memory). Best case is then one cycle in FETCH.
- `br_valid` already high on RESOLVE entry is accepted in that cycle.
- `pc_finish` is sampled in both ADVANCE and PC_WAIT. A finish coincident with `pc_start` goes straight to FETCH.
- Best-case non-branch loop: FETCH, ISSUE, ADVANCE, PC_WAIT = 4 cycles/instruction, given 1-cycle ack, ready and finish.
- `imem_ack`, `br_valid` and `pc_finish` are ignored outside the states that sample them.

## Configuration
- `IF_HALT_DETECT_EN` defined:
  - An ISSUE handshake on `instr`=32'hFFFF_FFFF sets `halted`=1 and goes to IDLE with no `pc_start`.
  - `halted` is sticky until reset; IDLE does not leave while `halted`=1.
- Undefined: `halted` is tied to 0, and 32'hFFFF_FFFF is handled as an ordinary non-branch instruction.

## Structure
- Shared package `mips_pkg`: opcode constants `OP_BEQ`, `OP_J`, `HALT_WORD`, and the FSM state enum.
- One sub-module, `if_field_extract`: combinational split of `instr` into opcode, sign-extended offset and 26-bit jump target.

## Test plan
- Reset low mid-FETCH with `imem_req`=1 → all outputs at reset values next edge; after reset high and `run`=1, the first `imem_addr` equals `pc`.
- `pc`=0x40, ack after 3 cycles, `imem_rdata`=0x08000123 (j) → `jump`=1, `jump_addr`=0x123, one `pc_start` pulse, `fetch_count`=1.
- `imem_rdata`=0x1000FFFE (beq), `br_valid`=1 with `br_taken`=1 two cycles after the handshake → `beq`=1, `branch_offset`=0xFFFFFFFE, `pc_start` after resolve.
- Same beq with `br_taken`=0 → `beq`=0, `jump`=0.
- `instr_ready` held low 5 cycles → `instr_valid` stays high and `instr` stable, no `pc_start`; `run` dropped in PC_WAIT → IDLE after `pc_finish`.
- With `IF_HALT_DETECT_EN`, fetch 0xFFFFFFFF → `halted`=1, no `pc_start`, no further `imem_req`; without the macro, `pc_start` pulses and fetching continues.
